// File: rtl/fetch_stage.sv
// Single-slot instruction fetch stage driving an SRAM-like instruction bus.
// Optional stall counter enabled with `define FETCH_PERFCNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [4:0]  EXC_ADEL = 5'h04
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        de_accept_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic        cancelled_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] perfcnt_fetch_stall_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        valid_r;
  logic [31:0] slot_pc_r;
  logic        cancelled_r;
  logic        exc_r;
  logic [4:0]  exccode_r;
  logic        misaligned_s;
  logic        unused_data_ok_s;

  // The returned data goes straight to decode; only the slot handshake matters here.
  assign unused_data_ok_s = inst_data_ok;

  assign misaligned_s = (pc_r[1:0] != 2'b00);
  assign inst_req     = (state_r == S_REQ) && !misaligned_s && !reset;
  assign inst_addr    = pc_r;

  assign valid_o     = valid_r;
  assign pc_o        = slot_pc_r;
  assign cancelled_o = cancelled_r;
  assign exc_o       = exc_r;
  assign exccode_o   = exccode_r;
  assign exc_miss_o  = 1'b0;

  // Slot FSM: allocate on bus accept or AdEL, free on decode accept, redirect overrides pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      valid_r     <= 1'b0;
      slot_pc_r   <= 32'd0;
      cancelled_r <= 1'b0;
      exc_r       <= 1'b0;
      exccode_r   <= 5'd0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (misaligned_s) begin
            state_r     <= S_ERR;
            valid_r     <= 1'b1;
            slot_pc_r   <= pc_r;
            exc_r       <= 1'b1;
            exccode_r   <= EXC_ADEL;
            cancelled_r <= redirect_i;
            if (redirect_i) begin
              pc_r <= redirect_pc_i;
            end else begin
              pc_r <= pc_r;
            end
          end else if (inst_addr_ok) begin
            state_r     <= S_WAIT;
            valid_r     <= 1'b1;
            slot_pc_r   <= pc_r;
            exc_r       <= 1'b0;
            cancelled_r <= redirect_i;
            if (redirect_i) begin
              pc_r <= redirect_pc_i;
            end else begin
              pc_r <= pc_r + 32'd4;
            end
          end else begin
            // Unaccepted request keeps its address unless redirected.
            if (redirect_i) begin
              pc_r <= redirect_pc_i;
            end else begin
              pc_r <= pc_r;
            end
          end
        end
        S_WAIT, S_ERR: begin
          if (de_accept_i) begin
            state_r     <= S_REQ;
            valid_r     <= 1'b0;
            cancelled_r <= 1'b0;
          end else if (redirect_i) begin
            cancelled_r <= 1'b1;
          end else begin
            cancelled_r <= cancelled_r;
          end
          if (redirect_i) begin
            pc_r <= redirect_pc_i;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r <= S_REQ;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic [31:0] perfcnt_r;

  // Counts cycles where a request is offered but the bus does not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfcnt_r <= 32'd0;
    end else if (inst_req && !inst_addr_ok) begin
      perfcnt_r <= perfcnt_r + 32'd1;
    end else begin
      perfcnt_r <= perfcnt_r;
    end
  end

  assign perfcnt_fetch_stall_o = perfcnt_r;
`else
  assign perfcnt_fetch_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a slot-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic        de_accept_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic        cancelled_o;
  logic        exc_o;
  logic        exc_miss_o;
  logic [4:0]  exccode_o;
  logic [31:0] perfcnt_fetch_stall_o;

  int checks = 0;
  int errors = 0;

  // Reference model: one fetch pointer plus one optional slot.
  logic [31:0] m_pc;
  logic        m_slot;
  logic [31:0] m_slot_pc;
  logic        m_exc;
  logic        m_cancel;
  logic [31:0] m_stall;

  fetch_stage dut (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .de_accept_i(de_accept_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .pc_o(pc_o), .cancelled_o(cancelled_o), .exc_o(exc_o),
    .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
    .perfcnt_fetch_stall_o(perfcnt_fetch_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef FETCH_PERFCNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input logic r, input logic aok, input logic dacc,
                      input logic redir, input logic [31:0] rpc);
    logic req;
    reset = r; inst_addr_ok = aok; de_accept_i = dacc;
    redirect_i = redir; redirect_pc_i = rpc;
    inst_data_ok = $urandom_range(0, 1);
    @(posedge clk);
    if (r) begin
      m_pc = 32'hBFC00000; m_slot = 1'b0; m_exc = 1'b0;
      m_cancel = 1'b0; m_slot_pc = 32'd0; m_stall = 32'd0;
    end else begin
      req = !m_slot && (m_pc % 4 == 0);
      if (req && !aok) m_stall = m_stall + 32'd1;
      if (!m_slot) begin
        if (m_pc % 4 != 0) begin
          m_slot = 1'b1; m_slot_pc = m_pc; m_exc = 1'b1; m_cancel = redir;
        end else if (aok) begin
          m_slot = 1'b1; m_slot_pc = m_pc; m_exc = 1'b0; m_cancel = redir;
          m_pc = m_pc + 32'd4;
        end
      end else if (dacc) begin
        m_slot = 1'b0;
      end else if (redir) begin
        m_cancel = 1'b1;
      end
      if (redir) m_pc = rpc;
    end
    @(negedge clk);
    check_val("inst_req", {31'd0, inst_req}, {31'd0, !reset && !m_slot && (m_pc % 4 == 0)});
    check_val("inst_addr", inst_addr, m_pc);
    check_val("valid_o", {31'd0, valid_o}, {31'd0, m_slot});
    check_val("exc_miss_o", {31'd0, exc_miss_o}, 32'd0);
    check_val("perfcnt", perfcnt_fetch_stall_o, exp_perf());
    if (m_slot) begin
      check_val("pc_o", pc_o, m_slot_pc);
      check_val("cancelled_o", {31'd0, cancelled_o}, {31'd0, m_cancel});
      check_val("exc_o", {31'd0, exc_o}, {31'd0, m_exc});
      if (m_exc) check_val("exccode_o", {27'd0, exccode_o}, 32'h4);
    end
  endtask

  initial begin
    // Reset state and reset-time request suppression
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check_val("rst_req", {31'd0, inst_req}, 32'd0);
    check_val("rst_pc_o", pc_o, 32'd0);
    check_val("rst_exccode", {27'd0, exccode_o}, 32'd0);
    check_val("rst_exc", {31'd0, exc_o}, 32'd0);
    check_val("rst_cancel", {31'd0, cancelled_o}, 32'd0);

    // Sequential fetch with accepts every other cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_val("seq0_pc_o", pc_o, 32'hBFC00000);
    check_val("seq0_addr", inst_addr, 32'hBFC00004);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_val("seq1_pc_o", pc_o, 32'hBFC00004);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_val("seq2_pc_o", pc_o, 32'hBFC00008);

    // Back-pressure holds the address
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("bp_addr", inst_addr, 32'hBFC00000);
`ifdef FETCH_PERFCNT_EN
    check_val("bp_perf", perfcnt_fetch_stall_o, 32'd3);
`else
    check_val("bp_perf", perfcnt_fetch_stall_o, 32'd0);
`endif

    // Redirect while a slot waits
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80001000);
    check_val("rd_cancel", {31'd0, cancelled_o}, 32'd1);
    check_val("rd_pc_o", pc_o, 32'hBFC00004);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("rd_addr", inst_addr, 32'h80001000);
    check_val("rd_req", {31'd0, inst_req}, 32'd1);

    // Misaligned redirect target raises AdEL
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80000002);
    check_val("adel_noreq", {31'd0, inst_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("adel_valid", {31'd0, valid_o}, 32'd1);
    check_val("adel_exc", {31'd0, exc_o}, 32'd1);
    check_val("adel_code", {27'd0, exccode_o}, 32'h4);
    check_val("adel_pc_o", pc_o, 32'h80000002);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h80000100);

    // Redirect, addr_ok and accept all in one cycle
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80002000);
    check_val("tri_cancel", {31'd0, cancelled_o}, 32'd1);
    check_val("tri_pc_o", pc_o, 32'h80000100);
    check_val("tri_addr", inst_addr, 32'h80002000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Reset during a pending request
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("mid_rst_addr", inst_addr, 32'hBFC00000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 32'hFFFF), 14'd0, 2'b00} + 32'h80000000;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = $urandom_range(1, 3);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-002 Parameter EXC_ADEL, default 5'h04, exccode reported for a misaligned fetch address.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_req  output  1  instruction fetch request (SRAM-like bus).
REQ-006 inst_addr  output  32  fetch address, always equal to the internal pc.
REQ-007 inst_addr_ok  input  1  request accepted by the bus this cycle.
REQ-008 inst_data_ok  input  1  instruction returned this cycle; the data goes directly to decode, and this block uses only the pulse.
REQ-009 de_accept_i  input  1  decode consumes the current slot this cycle.
REQ-010 redirect_i  input  1  flush-and-refetch request from execute or commit.
REQ-011 redirect_pc_i  input  32  new fetch address when redirect_i is high.
REQ-012 valid_o  output  1  a slot is presented to decode.
REQ-013 pc_o  output  32  pc of the presented slot.
REQ-014 cancelled_o  output  1  the presented slot is on a flushed path.
REQ-015 exc_o, exc_miss_o, exccode_o  output  1/1/5  slot exception flag, TLB-miss flag, and exception code.
REQ-016 perfcnt_fetch_stall_o  output  32  count of bus back-pressure cycles.

Function
REQ-017 The block SHALL hold at most one slot: the slot is allocated by addr_ok or AdEL and freed by de_accept_i.
REQ-018 The block SHALL use states REQ, WAIT and ERR.
- REQ drives inst_req=1.
- WAIT means the slot is full and awaiting de_accept_i.
- ERR means an AdEL slot is presented.
REQ-019 In REQ with pc[1:0]==0 and inst_addr_ok=1, the block SHALL load pc_o<=pc, valid_o<=1, exc_o<=0, cancelled_o<=0, pc<=pc+4 (mod 2^32), and enter WAIT.
REQ-020 In REQ with pc[1:0]!=0, the block SHALL keep inst_req=0 and, in the same cycle, load valid_o<=1, exc_o<=1, exccode_o<=EXC_ADEL, pc_o<=pc, and enter ERR.
REQ-021 In WAIT or ERR, a cycle with de_accept_i=1 SHALL clear valid_o and return to REQ; the next request SHALL appear in the following cycle.
REQ-022 inst_req SHALL be 0 in WAIT and ERR; the block never has more than one outstanding request.
REQ-023 While inst_req=1 and inst_addr_ok=0, the block SHALL hold inst_addr stable unless redirect_i=1.
REQ-024 When redirect_i=1, the block SHALL load pc<=redirect_pc_i, which takes priority over the pc+4 update.
REQ-025 If a slot is held and not accepted in the same cycle as redirect_i, the block SHALL set cancelled_o<=1, and the slot SHALL remain until de_accept_i.
REQ-026 If redirect_i and inst_addr_ok coincide, the accepted slot SHALL be presented with cancelled_o=1 and pc SHALL become redirect_pc_i.
REQ-027 If redirect_i and de_accept_i coincide, the slot SHALL be freed, and the next request SHALL use redirect_pc_i.
REQ-028 If redirect_i arrives in ERR, the block SHALL set cancelled_o=1 and leave exc_o unchanged; decode discards the slot.
REQ-029 exc_miss_o SHALL be constant 0; it is reserved for the ITLB.
REQ-030 pc_o, exc_o and exccode_o SHALL be stable while valid_o=1 and de_accept_i=0.

Reset
REQ-031 On reset=1 at a clock edge, the block SHALL load pc<=RESET_PC, state<=REQ, valid_o<=0, cancelled_o<=0, exc_o<=0, exc_miss_o<=0, exccode_o<=0, pc_o<=0 and perfcnt<=0.
REQ-032 Reset applied mid-request SHALL abandon the request; the bus is reset by the same reset, and no stale inst_data_ok is expected.
REQ-033 inst_req SHALL be 0 during reset and SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-034 With FETCH_PERFCNT_EN defined, perfcnt_fetch_stall_o SHALL increment by 1 (wrapping at 2^32) on every cycle with inst_req=1 and inst_addr_ok=0.
REQ-035 Without FETCH_PERFCNT_EN, the counter register SHALL be absent and perfcnt_fetch_stall_o SHALL be tied to 32'd0.

Verification
REQ-036 Release reset with addr_ok=1 and de_accept_i pulsed every other cycle -> inst_addr sequence BFC00000, BFC00004, BFC00008; one pc_o per accept.
REQ-037 Hold addr_ok=0 for 3 cycles after reset -> inst_addr stays BFC00000; perfcnt reads 3 if the macro is defined, else 0.
REQ-038 Apply redirect_i=1 with pc 80001000 while WAIT holds pc_o=BFC00004 -> cancelled_o=1 for that slot; after accept, the next inst_addr is 80001000.
REQ-039 Apply redirect_pc_i=80000002 -> no inst_req; valid_o=1, exc_o=1, exccode_o=04, pc_o=80000002 in the next cycle.
REQ-040 Assert redirect_i, inst_addr_ok and de_accept_i in the same cycle -> priorities match REQ-026/027; exactly one cancelled slot; pc equals the redirect target.
REQ-041 Assert reset while inst_req is pending -> the next cycle shows valid_o=0 and inst_addr=BFC00000.
